// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared state type and defaults for the delay generator and its monitor
package delay_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } dly_state_t;

    localparam int DLY_N     = 7500;
    localparam int DLY_CBITS = 13;
    localparam int DLY_TOL   = 2;
    localparam int DLY_LOCK  = 4;

endpackage

// File: rtl/delay_iv_counter.sv
// rtl/delay_iv_counter.sv - pulse interval counter: load to 1, hold, saturating increment, else cleared
module delay_iv_counter #(
    parameter int CBITS = 13,
    parameter int LIMIT = 7503
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             hold,
    output logic [CBITS-1:0] cnt,
    output logic             timeout
);

    localparam logic [CBITS-1:0] MAXV = '1;
    localparam logic [CBITS-1:0] LIM  = CBITS'(LIMIT);

    logic [CBITS-1:0] r_cnt;

    // Dropping en without load or hold clears the count, so the idle state always reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CBITS'(1);
        end else if (hold) begin
            r_cnt <= r_cnt;
        end else if (en) begin
            if (r_cnt != MAXV) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign cnt     = r_cnt;
    assign timeout = !load && !hold && (r_cnt == LIM);

endmodule

// File: rtl/delay_monitor.sv
// rtl/delay_monitor.sv - locks onto a periodic pulse train and flags early or missing pulses
module delay_monitor
    import delay_pkg::*;
#(
    parameter int N     = DLY_N,
    parameter int CBITS = DLY_CBITS,
    parameter int TOL   = DLY_TOL,
    parameter int LOCK  = DLY_LOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             clr,
    output logic             err,
    output logic             flg,
    output logic             early,
    output logic             late,
    output logic [CBITS-1:0] last_iv
);

    localparam int               GW = $clog2(LOCK + 1);
    localparam logic [CBITS-1:0] LO = CBITS'(N + 1 - TOL);
    localparam int               HI = N + 1 + TOL;

    if ((N + 2 + TOL > 2**CBITS - 1) || (TOL > N) || (LOCK < 1)) begin : g_param_check
        $error("delay_monitor: parameter set out of range");
    end

    dly_state_t       r_state;
    logic [GW-1:0]    r_good;
    logic             r_err;
    logic             r_flg;
    logic             r_early;
    logic             r_late;
    logic [CBITS-1:0] r_last_iv;

    logic [CBITS-1:0] w_cnt;
    logic             w_timeout;
    logic             w_en;
    logic             w_load;
    logic             w_hold;
    logic             w_is_early;

    // An acquisition timeout clears the counter on the same edge that returns to IDLE.
    assign w_en       = (r_state == LOCKED) || ((r_state == ACQ) && !w_timeout);
    assign w_load     = sig && (r_state != FAULT);
    assign w_hold     = (r_state == FAULT) && !clr;
    assign w_is_early = w_cnt < LO;

    delay_iv_counter #(
        .CBITS (CBITS),
        .LIMIT (HI)
    ) u_iv_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (w_en),
        .load    (w_load),
        .hold    (w_hold),
        .cnt     (w_cnt),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_good    <= '0;
            r_err     <= 1'b0;
            r_flg     <= 1'b0;
            r_early   <= 1'b0;
            r_late    <= 1'b0;
            r_last_iv <= '0;
        end else begin
            r_early <= 1'b0;
            r_late  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sig) begin
                        r_state <= ACQ;
                        r_good  <= '0;
                    end
                end
                ACQ: begin
                    if (sig) begin
                        r_last_iv <= w_cnt;
                        if (w_is_early) begin
                            r_early <= 1'b1;
                            r_good  <= '0;
                        end else if (r_good == GW'(LOCK - 1)) begin
                            r_good  <= GW'(LOCK);
                            r_state <= LOCKED;
                            r_flg   <= 1'b1;
                        end else begin
                            r_good <= r_good + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_late  <= 1'b1;
                        r_good  <= '0;
                        r_state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (sig) begin
                        r_last_iv <= w_cnt;
                        if (w_is_early) begin
                            r_early <= 1'b1;
                            r_state <= FAULT;
                            r_flg   <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_late  <= 1'b1;
                        r_state <= FAULT;
                        r_flg   <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                FAULT: begin
                    if (clr) begin
                        r_state <= IDLE;
                        r_good  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A fault can only be entered from the locked state.
    a_err_after_lock : assert property (@(posedge clk) disable iff (rst) $rose(r_err) |-> $past(r_flg));

    assign err     = r_err;
    assign flg     = r_flg;
    assign early   = r_early;
    assign late    = r_late;
    assign last_iv = r_last_iv;

endmodule

// File: doc/delay_monitor.md
# delay_monitor

Periodic-pulse checker for the `sig` output of the delay/pulse generator. It measures the spacing between `sig` pulses and locks once the spacing has matched the nominal period N+1 cycles, within ±TOL, LOCK times in a row. After locking it flags any early or missing pulse as a sticky fault. It sits on the consumer side of the generator and provides `err`/`flg` status for formal and simulation benches.

## Interface
- `N`, 7500: generator terminal count; nominal pulse spacing is N+1 cycles.
- `CBITS`, 13: interval counter width. Elaboration check: N+2+TOL ≤ 2^CBITS−1 and TOL ≤ N.
- `TOL`, 2: accepted deviation from N+1, in cycles, either side.
- `LOCK`, 4: consecutive good intervals needed to lock (≥1).
- `clk` input 1: the single clock; all logic is on posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `sig` input 1: monitored pulse, sampled on each posedge.
- `clr` input 1: synchronous fault clear.
- `err` output 1: sticky fault; high iff state is FAULT.
- `flg` output 1: locked; high iff state is LOCKED.
- `early` output 1: one-cycle pulse when an interval is shorter than N+1−TOL.
- `late` output 1: one-cycle pulse when a timeout occurs.
- `last_iv` output CBITS: most recent measured interval.

## Operation
- Interval counter `cnt`:
  - In IDLE: `cnt` holds 0.
  - Otherwise: a sampled `sig`=1 loads 1. With no pulse, `cnt` increments and saturates at 2^CBITS−1.
  - At a sampled pulse, the measured interval d = `cnt`, the number of cycles since the previous sampled pulse.
- Good interval: N+1−TOL ≤ d ≤ N+1+TOL. Early interval: d < N+1−TOL. A pulse on back-to-back cycles gives d=1 and counts as early.
- Timeout: `cnt` == N+1+TOL with `sig`=0 on the same edge. This is detected exactly once per interval.
- States (2-bit enum):
  - IDLE: `sig` → ACQ, `good`=0.
  - ACQ: good pulse → `good`+1; reaching LOCK moves to LOCKED. Early pulse → `good`=0, stay in ACQ (the pulse re-anchors). Timeout → IDLE.
  - LOCKED: good pulse → stay. Early pulse or timeout → FAULT.
  - FAULT: ignores `sig`; `cnt` holds. `clr` → IDLE.
- `clr` outside FAULT has no effect. `clr` in the same cycle as a violation in FAULT: `clr` wins and the next state is IDLE.
- `early` and `late` pulse in ACQ and LOCKED only. `last_iv` updates on every pulse sampled in ACQ or LOCKED.
- `good` counter width is $clog2(LOCK+1); it never exceeds LOCK.

## Timing
- Every output is registered. An event sampled at edge k is visible after edge k.
- Lock: `flg` rises after the edge that samples the (LOCK+1)-th pulse following IDLE.
- Fault: `err` rises and `flg` falls together, after the edge that samples the violating pulse or timeout.
- Asynchronous `rst` forces, immediately and regardless of `clk`: state IDLE, `cnt`=0, `good`=0, `err`=`flg`=`early`=`late`=0, `last_iv`=0. This applies mid-interval too. The first pulse after release is treated as the IDLE anchor.
- Embedded property: once `flg` has been high, `err` is 0 until the edge after a violation.

## Structure
- Package `delay_pkg`:
  - `dly_state_t` enum: IDLE, ACQ, LOCKED, FAULT.
  - Shared defaults `DLY_N`, `DLY_CBITS`, used by both the generator and this monitor.
- Sub-module `delay_iv_counter`: the load/increment/saturate counter. It takes `clk`, `rst`, `en`, `load`, `hold`, and outputs `cnt` and `timeout`.
- FSM, `good` counter and output registers live in `delay_monitor`.

## Test plan
Values below use N=7500, TOL=2, LOCK=4.
- 5 pulses spaced 7501 → `flg`=1 after the 5th pulse; `err`=0; `last_iv`=7501.
- Locked, then next pulse at 7497 → `early` pulse; `err`=1, `flg`=0; `last_iv`=7497.
- Locked, then no further pulse → `late` pulse 7503 cycles after the last pulse; `err`=1.
- Intervals 7499, 7503, 7501, 7500 → all accepted; `flg`=1 after the 4th interval; `early`/`late` never assert.
- In FAULT, `clr` and `sig` in the same cycle → IDLE, with `err` clearing after that edge; the next `sig` → ACQ.
- `rst` pulsed 3000 cycles into a locked interval → all outputs 0 immediately; 7501-spaced pulses then re-lock after 5 pulses.
